// File: rtl/mux_scan_param.sv
// Registered N_CH-to-1 channel multiplexer with a manual select mode and a masked
// round-robin scan mode that dwells DWELL accepted transfers on each enabled channel.
module mux_scan_param #(
    parameter  int N_CH  = 16,
    parameter  int W     = 1,
    parameter  int DWELL = 1,
    localparam int SEL_W = $clog2(N_CH)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_CH*W-1:0]   in_data,
    input  logic [SEL_W-1:0]    sel,
    input  logic                mode,
    input  logic [N_CH-1:0]     ch_mask,
    input  logic                out_ready,
    output logic                out_valid,
    output logic [W-1:0]        out_data,
    output logic [SEL_W-1:0]    out_ch,
    output logic                scan_wrap
);

    typedef enum logic {
        ST_MANUAL = 1'b0,
        ST_SCAN   = 1'b1
    } state_t;

    localparam logic [7:0] DWELL_C = 8'(DWELL);

    state_t            state_q, state_d;
    logic [SEL_W-1:0]  ptr_q, ptr_d;
    logic [7:0]        dwell_q, dwell_d;
    logic              out_valid_q, out_valid_d;
    logic [W-1:0]      out_data_q, out_data_d;
    logic [SEL_W-1:0]  out_ch_q, out_ch_d;
    logic              scan_wrap_q, scan_wrap_d;

    logic              load_s;
    logic              any_en_s;
    logic              sel_ok_s;
    logic [SEL_W-1:0]  lowest_s;
    logic [SEL_W-1:0]  base_ptr_s;
    logic [7:0]        base_cnt_s;
    logic [SEL_W-1:0]  chosen_s;
    logic [7:0]        cnt_new_s;
    logic [SEL_W-1:0]  nxt_s;

    // First enabled channel at or after (inclusive) / strictly after (exclusive) 'from',
    // wrapping modulo N_CH; the exclusive search may land back on 'from' itself.
    function automatic logic [SEL_W-1:0] next_enabled(
        input logic [N_CH-1:0]  mask,
        input logic [SEL_W-1:0] from,
        input logic             inclusive
    );
        logic [SEL_W-1:0] res;
        logic             found;
        logic [N_CH-1:0]  sh;
        int               idx;
        res   = from;
        found = 1'b0;
        for (int off = 0; off <= N_CH; off++) begin
            idx = (int'(from) + off) % N_CH;
            sh  = mask >> idx;
            if (!found && sh[0] && (inclusive || (off != 0))) begin
                found = 1'b1;
                res   = idx[SEL_W-1:0];
            end
        end
        return res;
    endfunction

    function automatic logic [W-1:0] channel_data(
        input logic [N_CH*W-1:0] bus,
        input logic [SEL_W-1:0]  ch
    );
        logic [N_CH*W-1:0] sh;
        sh = bus >> (int'(ch) * W);
        return sh[W-1:0];
    endfunction

    // Scan candidate selection; entering from MANUAL restarts at the lowest enabled channel.
    always_comb begin
        load_s   = !out_valid_q || out_ready;
        any_en_s = |ch_mask;
        sel_ok_s = (int'(sel) < N_CH);
        lowest_s = next_enabled(ch_mask, {SEL_W{1'b0}}, 1'b1);
        if (state_q == ST_SCAN) begin
            base_ptr_s = ptr_q;
            base_cnt_s = dwell_q;
        end else begin
            base_ptr_s = lowest_s;
            base_cnt_s = 8'd0;
        end
        chosen_s = next_enabled(ch_mask, base_ptr_s, 1'b1);
        if (chosen_s == base_ptr_s) begin
            cnt_new_s = base_cnt_s + 8'd1;
        end else begin
            cnt_new_s = 8'd1;
        end
        nxt_s = next_enabled(ch_mask, chosen_s, 1'b0);
    end

    // Next-state and output update, applied only at load slots.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        dwell_d     = dwell_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        scan_wrap_d = 1'b0;
        if (load_s) begin
            if (mode) begin
                state_d = ST_SCAN;
                if (any_en_s) begin
                    out_valid_d = 1'b1;
                    out_data_d  = channel_data(in_data, chosen_s);
                    out_ch_d    = chosen_s;
                    if (cnt_new_s == DWELL_C) begin
                        ptr_d       = nxt_s;
                        dwell_d     = 8'd0;
                        scan_wrap_d = (nxt_s <= chosen_s);
                    end else begin
                        ptr_d   = chosen_s;
                        dwell_d = cnt_new_s;
                    end
                end else begin
                    out_valid_d = 1'b0;
                end
            end else begin
                state_d = ST_MANUAL;
                if (sel_ok_s) begin
                    out_valid_d = 1'b1;
                    out_data_d  = channel_data(in_data, sel);
                    out_ch_d    = sel;
                end else begin
                    out_valid_d = 1'b0;
                end
            end
        end else begin
            state_d = state_q;
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_MANUAL;
            ptr_q       <= {SEL_W{1'b0}};
            dwell_q     <= 8'd0;
            out_valid_q <= 1'b0;
            out_data_q  <= {W{1'b0}};
            out_ch_q    <= {SEL_W{1'b0}};
            scan_wrap_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            dwell_q     <= dwell_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            scan_wrap_q <= scan_wrap_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;
    assign scan_wrap = scan_wrap_q;

endmodule

// File: tb/tb_mux_scan_param.sv
// Bench for mux_scan_param: three instances (16ch DWELL=1, 16ch DWELL=2, 5ch DWELL=1)
// share one stimulus stream and are checked every cycle against a transfer-level model.
module tb_mux_scan_param;

    logic         clk = 1'b0;
    logic         rst;
    logic         mode;
    logic         out_ready;
    logic [3:0]   sel;
    logic [2:0]   sel5;
    logic [15:0]  ch_mask;
    logic [127:0] in_data;

    logic         dv  [3];
    logic [7:0]   dd  [3];
    logic         dwp [3];
    logic [3:0]   dc1, dc2;
    logic [2:0]   dc5;

    int  checks   = 0;
    int  failures = 0;
    bit  run      = 1'b0;

    int  nch [3] = '{16, 16, 5};
    int  dwl [3] = '{1, 2, 1};
    bit  m_scan [3];
    int  m_ptr  [3];
    int  m_dw   [3];
    bit  e_valid[3];
    int  e_data [3];
    int  e_ch   [3];
    bit  e_wrap [3];

    int  seq_ch [5] = '{0, 3, 5, 0, 3};
    bit  seq_wr [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

    always #5 clk = ~clk;

    mux_scan_param #(.N_CH(16), .W(8), .DWELL(1)) u_d1 (
        .clk(clk), .rst(rst), .in_data(in_data), .sel(sel), .mode(mode),
        .ch_mask(ch_mask), .out_ready(out_ready), .out_valid(dv[0]),
        .out_data(dd[0]), .out_ch(dc1), .scan_wrap(dwp[0])
    );

    mux_scan_param #(.N_CH(16), .W(8), .DWELL(2)) u_d2 (
        .clk(clk), .rst(rst), .in_data(in_data), .sel(sel), .mode(mode),
        .ch_mask(ch_mask), .out_ready(out_ready), .out_valid(dv[1]),
        .out_data(dd[1]), .out_ch(dc2), .scan_wrap(dwp[1])
    );

    mux_scan_param #(.N_CH(5), .W(8), .DWELL(1)) u_d5 (
        .clk(clk), .rst(rst), .in_data(in_data[39:0]), .sel(sel5), .mode(mode),
        .ch_mask(ch_mask[4:0]), .out_ready(out_ready), .out_valid(dv[2]),
        .out_data(dd[2]), .out_ch(dc5), .scan_wrap(dwp[2])
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Enabled channel search over the instance's own channel count.
    function automatic int next_on(input int k, input int from, input bit incl);
        int c;
        for (int i = 0; i <= nch[k]; i++) begin
            c = (from + i) % nch[k];
            if ((incl || i != 0) && ch_mask[c]) return c;
        end
        return -1;
    endfunction

    task automatic model_step(input int k);
        int n, s, ch, np;
        bit any;
        n = nch[k];
        e_wrap[k] = 1'b0;
        if (rst) begin
            m_scan[k] = 1'b0; m_ptr[k] = 0; m_dw[k] = 0;
            e_valid[k] = 1'b0; e_data[k] = 0; e_ch[k] = 0;
        end else if (!e_valid[k] || out_ready) begin
            if (mode) begin
                any = 1'b0;
                for (int c = 0; c < n; c++) any = any | ch_mask[c];
                if (!any) begin
                    e_valid[k] = 1'b0;
                end else begin
                    if (!m_scan[k]) begin
                        m_ptr[k] = next_on(k, 0, 1'b1);
                        m_dw[k]  = 0;
                    end
                    ch = next_on(k, m_ptr[k], 1'b1);
                    if (ch != m_ptr[k]) m_dw[k] = 0;
                    m_dw[k] = m_dw[k] + 1;
                    e_valid[k] = 1'b1;
                    e_data[k]  = int'(in_data[ch*8 +: 8]);
                    e_ch[k]    = ch;
                    if (m_dw[k] == dwl[k]) begin
                        np = next_on(k, ch, 1'b0);
                        e_wrap[k] = (np <= ch);
                        m_ptr[k]  = np;
                        m_dw[k]   = 0;
                    end else begin
                        m_ptr[k] = ch;
                    end
                end
                m_scan[k] = 1'b1;
            end else begin
                m_scan[k] = 1'b0;
                s = (k == 2) ? int'(sel5) : int'(sel);
                if (s < n) begin
                    e_valid[k] = 1'b1;
                    e_data[k]  = int'(in_data[s*8 +: 8]);
                    e_ch[k]    = s;
                end else begin
                    e_valid[k] = 1'b0;
                end
            end
        end
    endtask

    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) model_step(k);
    end

    // Every-cycle comparison of all three instances against the model.
    always @(negedge clk) begin
        logic [3:0] act_ch;
        if (run) begin
            for (int k = 0; k < 3; k++) begin
                act_ch = (k == 0) ? dc1 : (k == 1) ? dc2 : {1'b0, dc5};
                chk($sformatf("d%0d_valid", k), 32'(dv[k]), 32'(e_valid[k]));
                chk($sformatf("d%0d_data", k), 32'(dd[k]), 32'(e_data[k]));
                chk($sformatf("d%0d_ch", k), 32'(act_ch), 32'(e_ch[k]));
                chk($sformatf("d%0d_wrap", k), 32'(dwp[k]), 32'(e_wrap[k]));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_pattern(input logic [7:0] base);
        for (int c = 0; c < 16; c++) in_data[c*8 +: 8] = 8'(base + 8'(c));
    endtask

    initial begin
        rst = 1'b1; mode = 1'b0; sel = 4'd0; sel5 = 3'd0;
        ch_mask = 16'h0000; out_ready = 1'b0; in_data = 128'd0;
        step();
        run = 1'b1;
        step();
        chk("lit_rst_valid", 32'(dv[0]), 32'd0);
        chk("lit_rst_data", 32'(dd[0]), 32'd0);
        chk("lit_rst_ch", 32'(dc1), 32'd0);
        chk("lit_rst_wrap", 32'(dwp[0]), 32'd0);

        // Manual select of channel 5.
        rst = 1'b0; mode = 1'b0; sel = 4'd5; sel5 = 3'd2; out_ready = 1'b1;
        set_pattern(8'hA0);
        step();
        chk("lit_man_valid", 32'(dv[0]), 32'd1);
        chk("lit_man_data", 32'(dd[0]), 32'hA5);
        chk("lit_man_ch", 32'(dc1), 32'd5);

        // Stall with changing inputs, then release.
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            sel = 4'(i + 10);
            in_data = {$urandom, $urandom, $urandom, $urandom};
            step();
        end
        chk("lit_stall_data", 32'(dd[0]), 32'hA5);
        chk("lit_stall_ch", 32'(dc1), 32'd5);
        chk("lit_stall_valid", 32'(dv[0]), 32'd1);
        out_ready = 1'b1; sel = 4'd9; set_pattern(8'hB0);
        step();
        chk("lit_release_data", 32'(dd[0]), 32'hB9);
        chk("lit_release_ch", 32'(dc1), 32'd9);

        // Out-of-range select on the 5-channel instance.
        sel5 = 3'd6;
        step();
        chk("lit_sel_oob_valid", 32'(dv[2]), 32'd0);
        chk("lit_sel_oob_ch", 32'(dc5), 32'd2);

        // Scan over channels 0,3,5.
        mode = 1'b1; ch_mask = 16'h0029; set_pattern(8'hA0);
        for (int i = 0; i < 5; i++) begin
            step();
            chk($sformatf("lit_scan_ch%0d", i), 32'(dc1), 32'(seq_ch[i]));
            chk($sformatf("lit_scan_wrap%0d", i), 32'(dwp[0]), 32'(seq_wr[i]));
        end

        // Mask change mid-scan redirects past the masked pointer.
        ch_mask = 16'h0300;
        step();
        chk("lit_remask_ch", 32'(dc1), 32'd8);
        for (int i = 0; i < 6; i++) begin
            out_ready = (i % 3 == 2);
            step();
        end

        // Single enabled channel, re-entered from manual.
        out_ready = 1'b1; mode = 1'b0;
        step();
        mode = 1'b1; ch_mask = 16'h0004;
        for (int i = 0; i < 4; i++) begin
            step();
            chk($sformatf("lit_single_ch%0d", i), 32'(dc2), 32'd2);
            chk($sformatf("lit_single_wrap%0d", i), 32'(dwp[1]), 32'(i % 2 == 1));
        end

        // Empty mask, then only the top channel.
        ch_mask = 16'h0000;
        step();
        chk("lit_empty_valid", 32'(dv[0]), 32'd0);
        chk("lit_empty_wrap", 32'(dwp[0]), 32'd0);
        ch_mask = 16'h8000;
        step();
        chk("lit_ch15_ch", 32'(dc1), 32'd15);
        chk("lit_ch15_valid", 32'(dv[0]), 32'd1);

        // Reset during a scan stall discards the held word.
        out_ready = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();
        chk("lit_rst2_valid", 32'(dv[0]), 32'd0);
        chk("lit_rst2_data", 32'(dd[0]), 32'd0);
        chk("lit_rst2_ch", 32'(dc1), 32'd0);
        chk("lit_rst2_d2_valid", 32'(dv[1]), 32'd0);
        rst = 1'b0; mode = 1'b0; sel = 4'd7; out_ready = 1'b1;
        step();
        chk("lit_post_rst_ch", 32'(dc1), 32'd7);
        chk("lit_post_rst_data", 32'(dd[0]), 32'hA7);

        // Mixed traffic.
        for (int i = 0; i < 200; i++) begin
            rst       = ($urandom_range(0, 49) == 0);
            mode      = ($urandom_range(0, 3) != 0);
            sel       = 4'($urandom);
            sel5      = 3'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 7) == 0) ch_mask = 16'($urandom & $urandom);
            in_data   = {$urandom, $urandom, $urandom, $urandom};
            step();
        end
        rst = 1'b0;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mux_scan_param.md
MUX_SCAN_PARAM -- requirements
Module: mux_scan_param

Interface
REQ-001 SHALL have parameter N_CH, default 16, number of input channels (2..256).
REQ-002 SHALL have parameter W, default 1, bits per channel (1..64).
REQ-003 SHALL have parameter DWELL, default 1, accepted transfers per channel before scan advances (1..255).
REQ-004 SHALL derive localparam SEL_W = clog2(N_CH); SEL_W is not overridable.
REQ-005 SHALL have port clk, input, 1, sole clock; all logic on rising edge.
REQ-006 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-007 SHALL have port in_data, input, N_CH*W, channel k at bits [k*W +: W].
REQ-008 SHALL have port sel, input, SEL_W, manual channel select.
REQ-009 SHALL have port mode, input, 1, 0 = MANUAL, 1 = SCAN.
REQ-010 SHALL have port ch_mask, input, N_CH, per-channel scan enable.
REQ-011 SHALL have port out_ready, input, 1, downstream accept.
REQ-012 SHALL have port out_valid, output, 1, out_data/out_ch valid.
REQ-013 SHALL have port out_data, output, W, selected channel sample.
REQ-014 SHALL have port out_ch, output, SEL_W, index of channel in out_data.
REQ-015 SHALL have port scan_wrap, output, 1, one-cycle pulse on scan wrap-around.

Function
REQ-016 SHALL register all outputs; no combinational path from any input to any output.
REQ-017 SHALL define a load slot as any cycle with out_valid=0 or out_ready=1; outputs update only at load slots.
REQ-018 SHALL hold out_data, out_ch, out_valid stable while out_valid=1 and out_ready=0.
REQ-019 SHALL implement two states MANUAL and SCAN; state follows mode, sampled at load slots only.
REQ-020 MANUAL load slot, sel < N_CH: out_data <= channel sel, out_ch <= sel, out_valid <= 1 (latency 1 cycle).
REQ-021 MANUAL load slot, sel >= N_CH: out_valid <= 0, out_data and out_ch hold.
REQ-022 MANUAL->SCAN transition: pointer <= lowest enabled channel, dwell count <= 0, that channel loaded in the same slot.
REQ-023 SCAN load slot: chosen = pointer if ch_mask[pointer]=1, else next enabled index above pointer, wrapping modulo N_CH.
REQ-024 SCAN load: out_data <= channel chosen, out_ch <= chosen, out_valid <= 1, dwell count increments.
REQ-025 When dwell count reaches DWELL: pointer advances to next enabled index after chosen (wrapping), dwell count <= 0.
REQ-026 scan_wrap SHALL pulse for one cycle in the cycle after an advance whose new pointer <= chosen, including single-enabled-channel case.
REQ-027 SCAN with ch_mask all zero: out_valid <= 0, pointer and dwell count hold, scan_wrap 0.
REQ-028 ch_mask change mid-scan takes effect at the next load slot per REQ-023; a masked pointer channel resets dwell count to 0 on redirection.
REQ-029 SCAN->MANUAL: pointer and dwell count hold but are ignored; re-entry to SCAN re-applies REQ-022.
REQ-030 scan_wrap SHALL be 0 whenever state is MANUAL.

Reset
REQ-031 rst=1 at a rising edge SHALL set out_valid=0, out_data=0, out_ch=0, scan_wrap=0, pointer=0, dwell count=0, state=MANUAL.
REQ-032 rst SHALL override all other inputs, including mid-stall; the stalled word is discarded.
REQ-033 First load slot after rst deassertion SHALL follow REQ-019..REQ-027 with no extra latency.

Verification (N_CH=16, W=8 unless stated)
REQ-034 MANUAL, out_ready=1, sel=5, in_data ch5=0xA5 -> next cycle out_valid=1, out_data=0xA5, out_ch=5.
REQ-035 MANUAL, out_valid=1, out_ready=0 for 4 cycles while sel and in_data change -> outputs unchanged; out_ready=1 -> new sample next cycle.
REQ-036 SCAN, DWELL=1, ch_mask=0x0029, out_ready=1 -> out_ch sequence 0,3,5,0,3 with scan_wrap high one cycle at each return to 0.
REQ-037 SCAN, DWELL=2, ch_mask=0x0004 -> out_ch=2 every cycle, scan_wrap pulse every 2nd transfer.
REQ-038 SCAN, ch_mask=0 -> out_valid=0, scan_wrap=0; ch_mask=0x8000 -> next load out_ch=15, out_valid=1.
REQ-039 rst asserted during stall (out_valid=1, out_ready=0, SCAN) -> next cycle all outputs 0, state MANUAL.
